// File: rtl/matrix_argmax.sv
// matrix_argmax
//   Scans the first L = min(C_size, MAX_M*MAX_N) IEEE-754 single-precision
//   elements of matrix_C (row-major) one element per clock and reports the
//   index and raw bits of the largest non-NaN element. Ties keep the lowest
//   index. NaNs are skipped but flagged.
//
// Ports
//   clk          : system clock, all state on rising edge
//   rst_n        : asynchronous active-low reset
//   start        : level request to scan (a held-high level does not retrigger)
//   C_size       : number of valid elements, clamped to MAX_M*MAX_N
//   matrix_C     : element array, must be stable while busy
//   busy         : high while a scan is in progress
//   done         : one-cycle pulse when the result outputs update
//   result_valid : at least one non-NaN element was scanned
//   class_idx    : index of the maximum element
//   max_val      : raw bits of the maximum element
//   nan_seen     : at least one scanned element was NaN
module matrix_argmax #(
  parameter int MAX_M = 10,
  parameter int MAX_N = 10,
  localparam int TOT   = MAX_M * MAX_N,
  localparam int IDX_W = (TOT > 1) ? $clog2(TOT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      C_size,
  input  logic [31:0]      matrix_C [TOT],
  output logic             busy,
  output logic             done,
  output logic             result_valid,
  output logic [IDX_W-1:0] class_idx,
  output logic [31:0]      max_val,
  output logic             nan_seen
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE, S_HOLD} state_t;

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [15:0]      TOT_16  = 16'(TOT);

  // Map float bits onto an unsigned total order: negatives are bit-inverted
  // (larger magnitude -> smaller key), positives get the sign bit set so they
  // sit above every negative. -0.0 lands just below +0.0.
  function automatic logic [31:0] f_key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  function automatic logic f_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  state_t           r_state;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_last;
  logic [31:0]      r_best_key;
  logic [31:0]      r_best_val;
  logic [IDX_W-1:0] r_best_idx;
  logic             r_have;
  logic             r_nan;
  logic             r_busy;
  logic             r_done;
  logic             r_valid;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_max;
  logic             r_nan_out;

  logic [15:0]      w_len;
  logic [31:0]      w_x;
  logic [31:0]      w_key;
  logic             w_nan;

  assign w_len = (C_size > TOT_16) ? TOT_16 : C_size;
  assign w_x   = matrix_C[r_cnt];
  assign w_key = f_key(w_x);
  assign w_nan = f_is_nan(w_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_last     <= '0;
      r_best_key <= '0;
      r_best_val <= '0;
      r_best_idx <= '0;
      r_have     <= 1'b0;
      r_nan      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_idx      <= '0;
      r_max      <= '0;
      r_nan_out  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt      <= '0;
            r_last     <= IDX_W'(w_len - 16'd1);
            r_best_key <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_have     <= 1'b0;
            r_nan      <= 1'b0;
            r_busy     <= 1'b1;
            // An empty matrix skips the scan entirely.
            r_state    <= (w_len == 16'd0) ? S_DONE : S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_nan) begin
            r_nan <= 1'b1;
          end else if (!r_have || (w_key > r_best_key)) begin
            r_have     <= 1'b1;
            r_best_key <= w_key;
            r_best_val <= w_x;
            r_best_idx <= r_cnt;
          end
          if (r_cnt == r_last) r_state <= S_DONE;
          else                 r_cnt   <= r_cnt + IDX_ONE;
        end
        S_DONE: begin
          r_valid   <= r_have;
          r_idx     <= r_best_idx;
          r_max     <= r_best_val;
          r_nan_out <= r_nan;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_HOLD;
        end
        S_HOLD: begin
          // Wait for start to drop so a level held high scans only once.
          if (!start) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign result_valid = r_valid;
  assign class_idx    = r_idx;
  assign max_val      = r_max;
  assign nan_seen     = r_nan_out;

endmodule

// File: doc/matrix_argmax.md
MATRIX_ARGMAX -- requirements
Module: matrix_argmax

Interface
REQ-001 Parameter MAX_M, default 10, maximum rows of matrix C.
REQ-002 Parameter MAX_N, default 10, maximum columns of matrix C.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level request to scan C; driven from the multiplier's mul_done.
REQ-006 C_size  input  16  number of valid C elements (M*N), row-major from index 0.
REQ-007 matrix_C  input  32 x (MAX_M*MAX_N) unpacked array  IEEE-754 single-precision elements.
REQ-008 busy  output  1  high while scanning.
REQ-009 done  output  1  one-cycle pulse when the result registers update.
REQ-010 result_valid  output  1  high if at least one non-NaN element was scanned.
REQ-011 class_idx  output  $clog2(MAX_M*MAX_N)  index of the maximum element.
REQ-012 max_val  output  32  raw bits of the maximum element.
REQ-013 nan_seen  output  1  high if any scanned element was NaN.

Function
REQ-014 FSM states SHALL be IDLE, SCAN, DONE, HOLD.
REQ-015 IDLE: start=1 -> SCAN; element counter=0, best tracker cleared, nan flag cleared; busy=1 from the next cycle.
REQ-016 Effective length SHALL be L = min(C_size, MAX_M*MAX_N).
REQ-017 L=0 on start SHALL go IDLE -> DONE directly, no elements scanned.
REQ-018 SCAN SHALL evaluate exactly one element matrix_C[cnt] per cycle, cnt incrementing 0..L-1; element cnt=L-1 -> DONE.
REQ-019 Ordering key SHALL be: x[31]=1 -> ~x; x[31]=0 -> x ^ 32'h8000_0000; compared unsigned (so -0.0 < +0.0, -inf smallest, +inf largest).
REQ-020 NaN (exponent 8'hFF, mantissa != 0) SHALL be skipped for comparison and set the internal NaN flag.
REQ-021 First non-NaN element SHALL load the tracker unconditionally; later elements replace it only if key strictly greater (ties keep the lowest index).
REQ-022 DONE (one cycle): class_idx, max_val, result_valid, nan_seen load from the tracker; done=1; busy=0.
REQ-023 No non-NaN element scanned -> result_valid=0, class_idx=0, max_val=32'h0000_0000.
REQ-024 DONE -> HOLD; HOLD -> IDLE only when start=0 (a held-high start SHALL NOT retrigger).
REQ-025 start changes during SCAN SHALL be ignored; C_size and matrix_C SHALL be stable during SCAN (caller contract).
REQ-026 Result outputs SHALL hold their values until the next DONE.
REQ-027 Latency: start seen in IDLE at cycle t -> done at cycle t+L+1 (t+1 for L=0).

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, result_valid=0, class_idx=0, max_val=0, nan_seen=0, counter and tracker cleared, including mid-SCAN.
REQ-029 After rst_n release, the block SHALL wait for start=1 in IDLE; a start already high at release starts a scan.

Verification
REQ-030 C_size=10, C=[0.1,0.5,-2.0,3.25,1.0,3.25,0,0,0,0] -> done 11 cycles after start, class_idx=3, max_val=32'h4050_0000, result_valid=1, nan_seen=0.
REQ-031 C_size=4, C=[-0.0,+0.0,-1.0,NaN 32'h7FC0_0000] -> class_idx=1, max_val=32'h0000_0000, nan_seen=1, result_valid=1.
REQ-032 C_size=3, all elements 32'h7FC0_0001 -> result_valid=0, class_idx=0, max_val=0, nan_seen=1.
REQ-033 C_size=0 -> done pulse one cycle after start, result_valid=0; C_size=200 with MAX 10x10 -> exactly 100 elements scanned, done at t+101.
REQ-034 start held high 50 cycles after done -> exactly one done pulse; start low then high -> second scan runs.
REQ-035 rst_n pulsed low at SCAN element 5 -> all outputs 0 within the reset cycle; no done until a new start.
